// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority by source index, with age counters
// so a waiting source is promoted once it has waited AGE_LIMIT cycles.
//   state            | meaning
//   g_valid=0        | idle, no write this cycle
//   g_valid=1        | write cycle for source g_idx, address g_rd
module wb_port_arbiter #(
   parameter int NUM_SRC   = 5,
   parameter int SEL_W     = 3,
   parameter int AGE_LIMIT = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [NUM_SRC-1:0]   req_valid,
   input  logic [5*NUM_SRC-1:0] req_rd,
   output logic [NUM_SRC-1:0]   req_ready,
   output logic [SEL_W-1:0]     wd_src,
   output logic                 rf_we,
   output logic [4:0]           rf_rd,
   output logic                 busy
);

   localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

   logic               g_valid;
   logic [SEL_W-1:0]   g_idx;
   logic [4:0]         g_rd;
   logic [3:0]         age [NUM_SRC];

   logic [NUM_SRC-1:0] g_oh;
   logic               g_src_valid;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] aged;
   logic [NUM_SRC-1:0] cand;
   logic [NUM_SRC-1:0] win_oh;
   logic [SEL_W-1:0]   win_idx;
   logic [4:0]         win_rd;

   // Decode of the current grant into a one-hot and the granted source's live valid.
   always_comb begin
      g_oh        = '0;
      g_src_valid = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (g_idx == SEL_W'(i)) begin
            g_oh[i]     = 1'b1;
            g_src_valid = req_valid[i];
         end
      end
   end

   assign busy      = g_valid;
   assign wd_src    = g_idx;
   assign rf_rd     = g_rd;
   assign req_ready = (g_valid && !flush) ? g_oh : '0;
   assign rf_we     = g_valid & g_src_valid & (g_rd != 5'd0) & ~flush;

   always_comb begin
      elig = req_valid;
      if (g_valid) elig = req_valid & ~g_oh;
      aged = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         aged[i] = elig[i] && (age[i] == AGE_MAX);
      end
      cand    = (|aged) ? aged : elig;
      win_oh  = cand & (~cand + NUM_SRC'(1));
      win_idx = '0;
      win_rd  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (win_oh[i]) begin
            win_idx = SEL_W'(i);
            win_rd  = req_rd[5*i +: 5];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_valid <= 1'b0;
         g_idx   <= '0;
         g_rd    <= '0;
         for (int i = 0; i < NUM_SRC; i++) age[i] <= '0;
      end else if (flush) begin
         g_valid <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) age[i] <= '0;
      end else begin
         g_valid <= |elig;
         if (|elig) begin
            g_idx <= win_idx;
            g_rd  <= win_rd;
         end
         // A valid source masked as the current grant keeps its age.
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!req_valid[i] || win_oh[i])
               age[i] <= '0;
            else if (elig[i] && age[i] != AGE_MAX)
               age[i] <= age[i] + 4'd1;
         end
      end
   end

endmodule
